conv1d_param_engine: RTL and testbench

Runtime-configurable sequential 1-D convolution engine, the parametrised successor of the fixed 8-tap/3-weight convolution FSM. Input samples and kernel weights are loaded through a write port, not hardcoded. Each run applies per-run length, kernel size, stride, bias and optional ReLU. Results stream out over a valid/ready handshake with backpressure, and invalid configurations are flagged.

---
 rtl/conv1d_param_engine_if.sv | 42 ++++
 rtl/conv1d_param_engine.sv | 162 ++++++++++++++++
 tb/tb_conv1d_param_engine.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv1d_param_engine_if.sv
// Bus bundle for conv1d_param_engine: buffer write port, run configuration,
// run control/status and the valid/ready result stream.
interface conv1d_param_engine_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int ACCUM_WIDTH = 24,
    parameter int ADDR_WIDTH  = 4
);
    logic                          wr_en;
    logic                          wr_sel;
    logic [ADDR_WIDTH-1:0]         wr_addr;
    logic signed [DATA_WIDTH-1:0]  wr_data;

    logic [ADDR_WIDTH:0]           cfg_input_len;
    logic [ADDR_WIDTH:0]           cfg_kernel_size;
    logic [ADDR_WIDTH:0]           cfg_stride;
    logic signed [DATA_WIDTH-1:0]  cfg_bias;
    logic                          cfg_relu;

    logic                          start;
    logic                          busy;
    logic                          done;
    logic                          error;

    logic                          out_valid;
    logic signed [ACCUM_WIDTH-1:0] out_data;
    logic                          out_last;
    logic                          out_ready;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data,
        output cfg_input_len, cfg_kernel_size, cfg_stride, cfg_bias, cfg_relu,
        output start, out_ready,
        input  busy, done, error, out_valid, out_data, out_last
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data,
        input  cfg_input_len, cfg_kernel_size, cfg_stride, cfg_bias, cfg_relu,
        input  start, out_ready,
        output busy, done, error, out_valid, out_data, out_last
    );
endinterface

// File: rtl/conv1d_param_engine.sv
// Runtime-configurable sequential 1-D convolution: one multiply-accumulate per
// cycle over loadable sample/weight buffers, results streamed with backpressure.
module conv1d_param_engine #(
    parameter int DATA_WIDTH    = 8,
    parameter int ACCUM_WIDTH   = 24,
    parameter int MAX_INPUT_LEN = 16,
    parameter int MAX_KERNEL    = 5,
    parameter int ADDR_WIDTH    = 4
) (
    input logic clk,
    input logic rst_n,
    conv1d_param_engine_if.slave bus
);

    localparam int KIDX_W = (MAX_KERNEL > 1) ? $clog2(MAX_KERNEL) : 1;
    localparam int CW     = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] IN_DEPTH  = CW'(MAX_INPUT_LEN);
    localparam logic [CW-1:0] KER_DEPTH = CW'(MAX_KERNEL);
    localparam logic [CW-1:0] ONE       = CW'(1);

    typedef enum logic [2:0] {IDLE, CHECK, MAC, EMIT, DONE} state_t;

    state_t                        state;
    logic signed [DATA_WIDTH-1:0]  in_buf [MAX_INPUT_LEN];
    logic signed [DATA_WIDTH-1:0]  w_buf  [MAX_KERNEL];

    logic [CW-1:0]                 len_r;
    logic [CW-1:0]                 ker_r;
    logic [CW-1:0]                 stride_r;
    logic signed [DATA_WIDTH-1:0]  bias_r;
    logic                          relu_r;

    logic [CW-1:0]                 win;
    logic [KIDX_W-1:0]             k;
    logic signed [ACCUM_WIDTH-1:0] acc;

    logic                          busy_r;
    logic                          done_r;
    logic                          error_r;
    logic                          out_valid_r;
    logic signed [ACCUM_WIDTH-1:0] out_data_r;
    logic                          out_last_r;

    logic [ADDR_WIDTH-1:0]         rd_idx;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACCUM_WIDTH-1:0] prod_ext;
    logic signed [ACCUM_WIDTH-1:0] acc_next;
    logic signed [ACCUM_WIDTH-1:0] bias_ext;
    logic                          k_last;
    logic                          win_last;
    logic                          cfg_bad;

    // Buffers are plain storage with no reset; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (bus.wr_en && state == IDLE) begin
            if (!bus.wr_sel && ({1'b0, bus.wr_addr} < IN_DEPTH))
                in_buf[bus.wr_addr] <= bus.wr_data;
            else if (bus.wr_sel && ({1'b0, bus.wr_addr} < KER_DEPTH))
                w_buf[bus.wr_addr[KIDX_W-1:0]] <= bus.wr_data;
        end
    end

    assign rd_idx   = win[ADDR_WIDTH-1:0] + ADDR_WIDTH'(k);
    assign prod     = in_buf[rd_idx] * w_buf[k];
    assign prod_ext = {{(ACCUM_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
    assign acc_next = acc + prod_ext;
    assign bias_ext = {{(ACCUM_WIDTH-DATA_WIDTH){bias_r[DATA_WIDTH-1]}}, bias_r};
    assign k_last   = (CW'(k) + ONE) == ker_r;

    // Widened by one bit so win+S cannot wrap before the comparison.
    assign win_last = ({1'b0, win} + {1'b0, stride_r}) > ({1'b0, len_r} - {1'b0, ker_r});

    assign cfg_bad  = (ker_r == '0) || (ker_r > KER_DEPTH) || (len_r > IN_DEPTH) ||
                      (len_r < ker_r) || (stride_r == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            len_r       <= '0;
            ker_r       <= '0;
            stride_r    <= '0;
            bias_r      <= '0;
            relu_r      <= 1'b0;
            win         <= '0;
            k           <= '0;
            acc         <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
        end else begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        len_r    <= bus.cfg_input_len;
                        ker_r    <= bus.cfg_kernel_size;
                        stride_r <= bus.cfg_stride;
                        bias_r   <= bus.cfg_bias;
                        relu_r   <= bus.cfg_relu;
                        busy_r   <= 1'b1;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (cfg_bad) begin
                        error_r <= 1'b1;
                        busy_r  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        win   <= '0;
                        k     <= '0;
                        acc   <= bias_ext;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    if (k_last) begin
                        out_valid_r <= 1'b1;
                        out_data_r  <= (relu_r && acc_next[ACCUM_WIDTH-1]) ? '0 : acc_next;
                        out_last_r  <= win_last;
                        state       <= EMIT;
                    end else begin
                        k <= k + KIDX_W'(1);
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                        if (out_last_r) begin
                            done_r <= 1'b1;
                            state  <= DONE;
                        end else begin
                            win   <= win + stride_r;
                            k     <= '0;
                            acc   <= bias_ext;
                            state <= MAC;
                        end
                    end
                end
                DONE: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.error     = error_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_last  = out_last_r;

endmodule

// File: tb/tb_conv1d_param_engine.sv
// Self-checking bench for conv1d_param_engine: directed scenarios plus randomized
// runs, all compared against an arithmetic convolution model.
module tb_conv1d_param_engine;

    localparam int DW  = 8;
    localparam int AW  = 24;
    localparam int IL  = 16;
    localparam int MK  = 5;
    localparam int ADW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    conv1d_param_engine_if #(.DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .ADDR_WIDTH(ADW)) bus ();

    conv1d_param_engine #(
        .DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .MAX_INPUT_LEN(IL),
        .MAX_KERNEL(MK), .ADDR_WIDTH(ADW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int mdl_in [IL];
    int mdl_w  [MK];
    logic signed [AW-1:0] exp_q [$];

    task automatic idle_inputs();
        bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.cfg_input_len = '0; bus.cfg_kernel_size = '0; bus.cfg_stride = '0;
        bus.cfg_bias = '0; bus.cfg_relu = 1'b0; bus.start = 1'b0; bus.out_ready = 1'b1;
    endtask

    // Model mirrors only the writes the engine is supposed to honour (issued in IDLE).
    task automatic write_buf(input logic sel, input int addr, input int data);
        logic signed [DW-1:0] d8;
        d8 = DW'(data);
        @(negedge clk);
        bus.wr_en = 1'b1; bus.wr_sel = sel; bus.wr_addr = ADW'(addr); bus.wr_data = d8;
        if (!sel && addr < IL) mdl_in[addr] = d8;
        if (sel && addr < MK) mdl_w[addr] = d8;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic build_expected(input int L, input int K, input int S,
                                  input int bias, input bit relu);
        longint sum;
        logic signed [AW-1:0] r;
        exp_q.delete();
        for (int win = 0; win + K <= L; win += S) begin
            sum = bias;
            for (int j = 0; j < K; j++) sum += longint'(mdl_in[win+j] * mdl_w[j]);
            r = sum[AW-1:0];
            if (relu && r < 0) r = '0;
            exp_q.push_back(r);
        end
    endtask

    task automatic load_basic(input int w0, input int w1, input int w2);
        int a [8];
        a = '{1, 2, 3, 4, 1, 1, 1, 1};
        for (int i = 0; i < 8; i++) write_buf(1'b0, i, a[i]);
        write_buf(1'b1, 0, w0);
        write_buf(1'b1, 1, w1);
        write_buf(1'b1, 2, w2);
    endtask

    // mode: 0 = ready always high (cadence checked), 1 = random ready,
    //       2 = first result held off for 4 cycles.
    task automatic run_cfg(input string name, input int L, input int K, input int S,
                           input int bias, input bit relu, input int mode,
                           input bit mid_write, input bit start_write);
        int cyc, outs, hold, total, addr;
        bit finished, rdy, exp_last;
        logic signed [AW-1:0] e;
        @(negedge clk);
        bus.cfg_input_len = (ADW+1)'(L); bus.cfg_kernel_size = (ADW+1)'(K);
        bus.cfg_stride = (ADW+1)'(S); bus.cfg_bias = DW'(bias); bus.cfg_relu = relu;
        bus.start = 1'b1;
        if (start_write) begin
            addr = $urandom_range(0, L - 1);
            bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_addr = ADW'(addr);
            bus.wr_data = DW'($urandom);
            mdl_in[addr] = bus.wr_data;
        end
        build_expected(L, K, S, bias, relu);
        total = exp_q.size();
        cyc = 0; outs = 0; hold = 0; finished = 0;
        while (!finished && cyc < 800) begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
            bus.wr_en = 1'b0;
            if (mid_write && cyc == 2) begin
                bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_addr = '0;
                bus.wr_data = DW'($urandom);
            end
            if (cyc == 1) begin
                n_cmp++;
                if (bus.busy !== 1'b1) begin
                    n_fail++; $display("[TB] FAIL %s busy_after_start: got %b want 1", name, bus.busy);
                end
            end
            if (bus.error !== 1'b0) begin
                n_cmp++; n_fail++;
                $display("[TB] FAIL %s spurious_error at cycle %0d: got 1 want 0", name, cyc);
            end
            rdy = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("[TB] FAIL %s extra_output: got %0d want none", name, bus.out_data);
                end else begin
                    e = exp_q[0];
                    exp_last = (exp_q.size() == 1);
                    n_cmp++;
                    if (bus.out_data !== e) begin
                        n_fail++; $display("[TB] FAIL %s out_data[%0d]: got %0d want %0d", name, outs, bus.out_data, e);
                    end
                    n_cmp++;
                    if (bus.out_last !== exp_last) begin
                        n_fail++; $display("[TB] FAIL %s out_last[%0d]: got %b want %b", name, outs, bus.out_last, exp_last);
                    end
                    if (mode == 0) begin
                        n_cmp++;
                        if (cyc != K + 2 + outs * (K + 1)) begin
                            n_fail++; $display("[TB] FAIL %s valid_cycle[%0d]: got %0d want %0d", name, outs, cyc, K + 2 + outs * (K + 1));
                        end
                    end
                    if (mode == 2 && outs == 0 && hold < 4) begin
                        rdy = 1'b0;
                        hold++;
                    end
                    if (rdy) begin
                        void'(exp_q.pop_front());
                        outs++;
                    end
                end
            end
            bus.out_ready = rdy;
            if (bus.done === 1'b1) begin
                finished = 1;
                bus.start = 1'b1;
            end
        end
        bus.out_ready = 1'b1;
        if (!finished) begin
            n_cmp++; n_fail++;
            $display("[TB] FAIL %s timeout: got no done after %0d cycles want done", name, cyc);
            bus.start = 1'b0;
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            return;
        end
        n_cmp++;
        if (outs != total) begin
            n_fail++; $display("[TB] FAIL %s output_count: got %0d want %0d", name, outs, total);
        end
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++;
        if ({bus.busy, bus.done, bus.out_valid} !== 3'b000) begin
            n_fail++; $display("[TB] FAIL %s after_done busy/done/valid: got %b want 000", name, {bus.busy, bus.done, bus.out_valid});
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.out_valid, bus.out_last, bus.done, bus.error} !== 5'b0) begin
            n_fail++; $display("[TB] FAIL reset_flags: got %b want 00000", {bus.busy, bus.out_valid, bus.out_last, bus.done, bus.error});
        end
        n_cmp++;
        if (bus.out_data !== '0) begin
            n_fail++; $display("[TB] FAIL reset_out_data: got %0d want 0", bus.out_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        load_basic(1, 2, 1);
        @(negedge clk);
        bus.cfg_input_len = 5'd8; bus.cfg_kernel_size = 5'd3; bus.cfg_stride = 5'd1;
        bus.cfg_bias = '0; bus.cfg_relu = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_fail++; $display("[TB] FAIL reset_pre_busy: got %b want 1", bus.busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.out_valid, bus.done, bus.error} !== 4'b0) begin
            n_fail++; $display("[TB] FAIL reset_async_mid_mac: got %b want 0000", {bus.busy, bus.out_valid, bus.done, bus.error});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.out_valid, bus.done} !== 3'b0) begin
            n_fail++; $display("[TB] FAIL reset_idle_after_release: got %b want 000", {bus.busy, bus.out_valid, bus.done});
        end
    endtask

    task automatic test_basic();
        run_cfg("basic", 8, 3, 1, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_stride_bias_backpressure();
        run_cfg("stride_bias_bp", 8, 3, 2, 1, 1'b0, 2, 1'b0, 1'b0);
    endtask

    task automatic test_relu();
        load_basic(-1, 0, 0);
        run_cfg("relu_on", 8, 3, 1, 0, 1'b1, 0, 1'b0, 1'b0);
        run_cfg("relu_off", 8, 3, 1, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic check_invalid(input string name, input int L, input int K, input int S);
        int errs, valids, dones;
        @(negedge clk);
        bus.cfg_input_len = (ADW+1)'(L); bus.cfg_kernel_size = (ADW+1)'(K);
        bus.cfg_stride = (ADW+1)'(S); bus.cfg_bias = '0; bus.cfg_relu = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++;
        if ({bus.busy, bus.error} !== 2'b10) begin
            n_fail++; $display("[TB] FAIL %s check_cycle busy/error: got %b want 10", name, {bus.busy, bus.error});
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.error} !== 2'b01) begin
            n_fail++; $display("[TB] FAIL %s error_pulse busy/error: got %b want 01", name, {bus.busy, bus.error});
        end
        errs = 0; valids = 0; dones = 0;
        repeat (8) begin
            @(negedge clk);
            errs   += int'(bus.error === 1'b1);
            valids += int'(bus.out_valid === 1'b1 || bus.busy === 1'b1);
            dones  += int'(bus.done === 1'b1);
        end
        n_cmp++;
        if (errs + valids + dones != 0) begin
            n_fail++; $display("[TB] FAIL %s after_error extra err/valid/done: got %0d/%0d/%0d want 0/0/0", name, errs, valids, dones);
        end
    endtask

    task automatic test_invalid();
        check_invalid("inv_k0", 8, 0, 1);
        check_invalid("inv_l_lt_k", 2, 3, 1);
        check_invalid("inv_s0", 8, 3, 0);
        check_invalid("inv_k_big", 8, 6, 1);
        check_invalid("inv_l_big", 17, 3, 1);
    endtask

    task automatic test_write_protect();
        load_basic(1, 2, 1);
        run_cfg("wp_mid_run", 8, 3, 1, 0, 1'b0, 0, 1'b1, 1'b0);
        write_buf(1'b1, 7, 99);
        run_cfg("wp_rerun", 8, 3, 1, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_boundary();
        for (int i = 0; i < IL; i++) write_buf(1'b0, i, int'($urandom_range(0, 255)) - 128);
        for (int i = 0; i < MK; i++) write_buf(1'b1, i, -128);
        run_cfg("bnd_full", 16, 5, 1, -128, 1'b0, 0, 1'b0, 1'b0);
        run_cfg("bnd_l_eq_k", 5, 5, 3, 7, 1'b0, 0, 1'b0, 1'b0);
        run_cfg("bnd_big_stride", 16, 1, 16, 0, 1'b1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int K, L, S;
        for (int i = 0; i < IL; i++) write_buf(1'b0, i, int'($urandom_range(0, 255)) - 128);
        for (int i = 0; i < MK; i++) write_buf(1'b1, i, int'($urandom_range(0, 255)) - 128);
        for (int r = 0; r < 8; r++) begin
            K = $urandom_range(1, MK);
            L = $urandom_range(K, IL);
            S = $urandom_range(1, 6);
            run_cfg($sformatf("rand%0d", r), L, K, S, int'($urandom_range(0, 255)) - 128,
                    1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_basic();
        test_stride_bias_backpressure();
        test_relu();
        test_invalid();
        test_write_protect();
        test_boundary();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
